// File: rtl/tpu_cmd_pkg.sv
// Shared command layout for the GEMM command queue and the config slave that packs commands.
// Field offsets match the 64-bit word: [63:54]D [53:44]C [43:34]B [33:24]A [23:16]N [15:8]K [7:0]M.
package tpu_cmd_pkg;

    localparam int TPU_ADDR_W = 10;
    localparam int TPU_LEN_W  = 8;
    localparam int TPU_CMD_W  = 64;

    localparam int M_LSB = 0;
    localparam int K_LSB = 8;
    localparam int N_LSB = 16;
    localparam int A_LSB = 24;
    localparam int B_LSB = 34;
    localparam int C_LSB = 44;
    localparam int D_LSB = 54;

    typedef struct packed {
        logic [TPU_ADDR_W-1:0] addr_d;
        logic [TPU_ADDR_W-1:0] addr_c;
        logic [TPU_ADDR_W-1:0] addr_b;
        logic [TPU_ADDR_W-1:0] addr_a;
        logic [TPU_LEN_W-1:0]  n_len;
        logic [TPU_LEN_W-1:0]  k_len;
        logic [TPU_LEN_W-1:0]  m_len;
    } tpu_cmd_t;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_e;

    function automatic logic cmd_has_zero_len(input tpu_cmd_t cmd);
        return (cmd.m_len == '0) || (cmd.k_len == '0) || (cmd.n_len == '0);
    endfunction

endpackage

// File: rtl/tpu_cmd_fifo_mem.sv
// Command storage: one write port, asynchronous read of the head entry.
// Storage is intentionally unreset; validity is tracked by the queue control.
module tpu_cmd_fifo_mem
    import tpu_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  tpu_cmd_t                 wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output tpu_cmd_t                 rdata
);

    tpu_cmd_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tpu_cmd_queue.sv
// GEMM command FIFO + decoder between the config slave and the matrix sequencer.
// Validates pushes, buffers DEPTH commands and presents the head via valid/ready.
//
// state     | meaning
// ----------+--------------------------------------------
// Q_EMPTY   | count == 0, exe_valid low, decoded fields 0
// Q_PARTIAL | 0 < count < DEPTH
// Q_FULL    | count == DEPTH, cmd_ready low
module tpu_cmd_queue
    import tpu_cmd_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       soft_rst,
    input  logic                       cmd_valid,
    input  logic [63:0]                cmd_data,
    output logic                       cmd_ready,
    output logic                       exe_valid,
    input  logic                       exe_ready,
    output logic [LEN_WIDTH-1:0]       exe_m_len,
    output logic [LEN_WIDTH-1:0]       exe_k_len,
    output logic [LEN_WIDTH-1:0]       exe_n_len,
    output logic [ADDR_WIDTH-1:0]      exe_addr_a,
    output logic [ADDR_WIDTH-1:0]      exe_addr_b,
    output logic [ADDR_WIDTH-1:0]      exe_addr_c,
    output logic [ADDR_WIDTH-1:0]      exe_addr_d,
    input  logic                       exec_busy,
    input  logic                       exec_done,
    output logic                       cu_busy,
    output logic                       compute_done_irq,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       err_overflow,
    output logic                       err_zero_len
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    q_state_e         state_q, state_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_zl_q, err_zl_d;
    logic             irq_q, irq_d;

    tpu_cmd_t         cmd_in;
    tpu_cmd_t         head;
    logic [63:0]      head_raw;
    logic             zero_len;
    logic             is_full;
    logic             push_acc;
    logic             pop;

    assign cmd_in   = cmd_data;
    assign zero_len = cmd_has_zero_len(cmd_in);
    assign is_full  = (state_q == Q_FULL);
    // Full check uses the registered state only: a pop in the same cycle does not free a slot.
    assign push_acc = cmd_valid && !is_full && !zero_len;
    assign pop      = exe_valid && exe_ready;

    tpu_cmd_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc && !soft_rst),
        .waddr (wr_ptr_q),
        .wdata (cmd_in),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        err_ovf_d = err_ovf_q;
        err_zl_d  = err_zl_q;
        irq_d     = exec_done;

        if (soft_rst) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            state_d   = Q_EMPTY;
            err_ovf_d = 1'b0;
            err_zl_d  = 1'b0;
            irq_d     = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({push_acc, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            // Both causes can be flagged by the same rejected push.
            if (cmd_valid && is_full) begin
                err_ovf_d = 1'b1;
            end
            if (cmd_valid && zero_len) begin
                err_zl_d = 1'b1;
            end

            case (state_q)
                Q_EMPTY: begin
                    if (push_acc) begin
                        state_d = Q_PARTIAL;
                    end
                end
                Q_PARTIAL: begin
                    if (push_acc && !pop && (count_q == CNT_W'(DEPTH-1))) begin
                        state_d = Q_FULL;
                    end else if (pop && !push_acc && (count_q == CNT_W'(1))) begin
                        state_d = Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    if (pop) begin
                        state_d = Q_PARTIAL;
                    end
                end
                default: state_d = Q_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= Q_EMPTY;
            err_ovf_q <= 1'b0;
            err_zl_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            err_ovf_q <= err_ovf_d;
            err_zl_q  <= err_zl_d;
            irq_q     <= irq_d;
        end
    end

    assign exe_valid        = (state_q != Q_EMPTY);
    assign cmd_ready        = (state_q != Q_FULL);
    assign cu_busy          = exe_valid || exec_busy;
    assign compute_done_irq = irq_q;
    assign q_count          = count_q;
    assign err_overflow     = err_ovf_q;
    assign err_zero_len     = err_zl_q;

    // Unwritten storage may hold anything, so the head is masked while empty.
    assign head_raw   = exe_valid ? head : '0;
    assign exe_m_len  = head_raw[M_LSB +: LEN_WIDTH];
    assign exe_k_len  = head_raw[K_LSB +: LEN_WIDTH];
    assign exe_n_len  = head_raw[N_LSB +: LEN_WIDTH];
    assign exe_addr_a = head_raw[A_LSB +: ADDR_WIDTH];
    assign exe_addr_b = head_raw[B_LSB +: ADDR_WIDTH];
    assign exe_addr_c = head_raw[C_LSB +: ADDR_WIDTH];
    assign exe_addr_d = head_raw[D_LSB +: ADDR_WIDTH];

endmodule

// File: tb/tb_tpu_cmd_queue.sv
// Scoreboard bench for tpu_cmd_queue: a plain queue of 64-bit commands is the reference,
// a negedge monitor compares the presented head against it and retires entries on handshake.
module tb_tpu_cmd_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_rst;
    logic        cmd_valid;
    logic [63:0] cmd_data;
    logic        cmd_ready;
    logic        exe_valid;
    logic        exe_ready;
    logic [7:0]  exe_m_len, exe_k_len, exe_n_len;
    logic [9:0]  exe_addr_a, exe_addr_b, exe_addr_c, exe_addr_d;
    logic        exec_busy;
    logic        exec_done;
    logic        cu_busy;
    logic        compute_done_irq;
    logic [2:0]  q_count;
    logic        err_overflow;
    logic        err_zero_len;

    tpu_cmd_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (10),
        .LEN_WIDTH  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .soft_rst         (soft_rst),
        .cmd_valid        (cmd_valid),
        .cmd_data         (cmd_data),
        .cmd_ready        (cmd_ready),
        .exe_valid        (exe_valid),
        .exe_ready        (exe_ready),
        .exe_m_len        (exe_m_len),
        .exe_k_len        (exe_k_len),
        .exe_n_len        (exe_n_len),
        .exe_addr_a       (exe_addr_a),
        .exe_addr_b       (exe_addr_b),
        .exe_addr_c       (exe_addr_c),
        .exe_addr_d       (exe_addr_d),
        .exec_busy        (exec_busy),
        .exec_done        (exec_done),
        .cu_busy          (cu_busy),
        .compute_done_irq (compute_done_irq),
        .q_count          (q_count),
        .err_overflow     (err_overflow),
        .err_zero_len     (err_zero_len)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    bit          exp_ovf = 1'b0;
    bit          exp_zl  = 1'b0;
    bit          exp_irq = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input int m, input int k, input int n,
                                       input int a, input int b, input int c, input int d);
        logic [63:0] w;
        w = {d[9:0], c[9:0], b[9:0], a[9:0], n[7:0], k[7:0], m[7:0]};
        return w;
    endfunction

    function automatic logic [63:0] rnd_cmd(input bit allow_zero);
        int m, k, n;
        m = (allow_zero && $urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
        k = (allow_zero && $urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
        n = (allow_zero && $urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
        return mk(m, k, n, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023));
    endfunction

    // Head of the reference queue must be on the outputs whenever exe_valid is high.
    always @(negedge clk) begin
        if (!rst && exe_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor_unexpected_valid: got exe_valid=1 expected 0 at %0t", $time);
            end else begin
                chk("head_m", exe_m_len,  exp_q[0][7:0]);
                chk("head_k", exe_k_len,  exp_q[0][15:8]);
                chk("head_n", exe_n_len,  exp_q[0][23:16]);
                chk("head_a", exe_addr_a, exp_q[0][33:24]);
                chk("head_b", exe_addr_b, exp_q[0][43:34]);
                chk("head_c", exe_addr_c, exp_q[0][53:44]);
                chk("head_d", exe_addr_d, exp_q[0][63:54]);
                if (exe_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_status();
        int sz;
        sz = exp_q.size();
        chk("q_count",   q_count,   sz);
        chk("exe_valid", exe_valid, sz != 0);
        chk("cmd_ready", cmd_ready, sz != DEPTH);
        chk("cu_busy",   cu_busy,   (sz != 0) || exec_busy);
        chk("err_overflow", err_overflow, exp_ovf);
        chk("err_zero_len", err_zero_len, exp_zl);
        chk("compute_done_irq", compute_done_irq, exp_irq);
        if (sz == 0) begin
            chk("empty_fields", {exe_addr_d, exe_addr_c, exe_addr_b, exe_addr_a,
                                 exe_n_len, exe_k_len, exe_m_len}, 64'h0);
        end
    endtask

    // Called at posedge+1; drives one cycle of inputs and checks the state after the next edge.
    task automatic step(input bit v, input logic [63:0] d, input bit rdy,
                        input bit done, input bit busy, input bit srst);
        bit acc, ovf, zl;
        cmd_valid = v;
        cmd_data  = d;
        exe_ready = rdy;
        exec_done = done;
        exec_busy = busy;
        soft_rst  = srst;
        zl  = v && (d[7:0] == 0 || d[15:8] == 0 || d[23:16] == 0);
        ovf = v && (exp_q.size() == DEPTH);
        acc = v && !zl && !ovf;
        @(posedge clk);
        #1;
        if (srst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_zl  = 1'b0;
            exp_irq = 1'b0;
        end else begin
            if (acc) exp_q.push_back(d);
            exp_ovf = exp_ovf | ovf;
            exp_zl  = exp_zl | zl;
            exp_irq = done;
        end
        check_status();
    endtask

    task automatic idle();
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        cmd_valid = 1'b0;
        exe_ready = 1'b0;
        exec_done = 1'b0;
        exec_busy = 1'b0;
        soft_rst  = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_zl  = 1'b0;
        exp_irq = 1'b0;
        #1;
        check_status();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_status();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] d1;
        rst       = 1'b1;
        soft_rst  = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 64'h0;
        exe_ready = 1'b0;
        exec_busy = 1'b0;
        exec_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        rst = 1'b0;
        check_status();

        // Single push: exe_valid one cycle later, exact field decode.
        d1 = mk(16, 16, 16, 'h010, 'h020, 'h030, 'h3FF);
        step(1'b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_m", exe_m_len, 64'd16);
        chk("t1_a", exe_addr_a, 64'h010);
        chk("t1_d", exe_addr_d, 64'h3FF);
        idle();
        drain();

        // Fill, overflow, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, rnd_cmd(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, rnd_cmd(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        // Push while full with a concurrent pop is still dropped.
        step(1'b1, rnd_cmd(1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Zero length push rejected.
        step(1'b1, mk(5, 0, 7, 1, 2, 3, 4), 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Push and pop together at count 2, across pointer wrap.
        step(1'b1, rnd_cmd(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, rnd_cmd(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, rnd_cmd(1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-to-back exec_done, then busy with an empty queue.
        idle();
        step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        // Soft reset with three entries, both flags set and a concurrent push.
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rnd_cmd(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(0, 3, 3, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, rnd_cmd(1'b0), 1'b0, 1'b1, 1'b0, 1'b1);
        idle();

        // Async reset mid-stream.
        step(1'b1, rnd_cmd(1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(9, 9, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0);
        async_reset();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            step($urandom_range(0, 2) != 0, rnd_cmd(1'b1), $urandom_range(0, 1) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 49) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
